// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: frame FSM, edge/bit counters and checker strobes.
// Defining UART_RX_FRAME_ERR_EN adds a one-cycle frame_err pulse on aborted frames.
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] p_r;
    logic [5:0] p_nxt_s;
    logic [5:0] edge_nxt_s;
    logic [3:0] bit_nxt_s;
    logic [5:0] strb_pt_s;
    logic       bit_end_s;
    logic       valid_nxt_s;
    logic       strt_nxt_s;
    logic       deser_nxt_s;
    logic       par_nxt_s;
    logic       stp_nxt_s;

    // Unsupported oversampling factors fall back to 8 so the counters always wrap sanely.
    function automatic logic [5:0] legal_p(input logic [5:0] value);
        if ((value < 6'd8) || value[0]) begin
            return 6'd8;
        end else begin
            return value;
        end
    endfunction

    assign bit_end_s = (state_r != IDLE) && (edge_cnt == (p_r - 6'd1));

    // Next-state, counter and data_valid decode.
    always_comb begin
        state_nxt_s = state_r;
        p_nxt_s     = p_r;
        valid_nxt_s = 1'b0;
        if (state_r == IDLE) begin
            edge_nxt_s = 6'd0;
            bit_nxt_s  = 4'd0;
        end else if (bit_end_s) begin
            edge_nxt_s = 6'd0;
            bit_nxt_s  = bit_cnt + 4'd1;
        end else begin
            edge_nxt_s = edge_cnt + 6'd1;
            bit_nxt_s  = bit_cnt;
        end
        case (state_r)
            IDLE: begin
                if (!rx_in) begin
                    state_nxt_s = START;
                    p_nxt_s     = legal_p(prescale);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s = strt_glitch ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_cnt == 4'd8)) begin
                    state_nxt_s = par_en ? PARITY : STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = par_err ? IDLE : STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = !stp_err;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (state_nxt_s == IDLE) begin
            edge_nxt_s = 6'd0;
            bit_nxt_s  = 4'd0;
        end else begin
            edge_nxt_s = edge_nxt_s;
            bit_nxt_s  = bit_nxt_s;
        end
    end

    // Strobes are registered, so they are decoded from the next counter value.
    assign strb_pt_s   = p_nxt_s - 6'd2;
    assign strt_nxt_s  = (state_nxt_s == START)  && (edge_nxt_s == strb_pt_s);
    assign deser_nxt_s = (state_nxt_s == DATA)   && (edge_nxt_s == strb_pt_s);
    assign par_nxt_s   = (state_nxt_s == PARITY) && (edge_nxt_s == strb_pt_s);
    assign stp_nxt_s   = (state_nxt_s == STOP)   && (edge_nxt_s == strb_pt_s);

    // State, counters and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            p_r         <= 6'd0;
            edge_cnt    <= 6'd0;
            bit_cnt     <= 4'd0;
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            p_r         <= p_nxt_s;
            edge_cnt    <= edge_nxt_s;
            bit_cnt     <= bit_nxt_s;
            dat_samp_en <= (state_nxt_s != IDLE);
            strt_chk_en <= strt_nxt_s;
            deser_en    <= deser_nxt_s;
            par_chk_en  <= par_nxt_s;
            stp_chk_en  <= stp_nxt_s;
            data_valid  <= valid_nxt_s;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic ferr_nxt_s;

    assign ferr_nxt_s = bit_end_s && (((state_r == START)  && strt_glitch) ||
                                      ((state_r == PARITY) && par_err)     ||
                                      ((state_r == STOP)   && stp_err));

    // Frame error pulse, aligned with where data_valid would have appeared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: random frames against a timeline model
// derived from the frame rules (bit k occupies cycles S+k*P .. S+k*P+P-1).
module tb_uart_rx_ctrl;

    localparam int MAXC = 20000;
`ifdef UART_RX_FRAME_ERR_EN
    localparam int NSEL = 9;
`else
    localparam int NSEL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd16;
    logic       par_en = 1'b0;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;

    bit glitch_cfg = 1'b0;
    bit perr_cfg = 1'b0;
    bit serr_cfg = 1'b0;

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    int prev_end = 0;
    int obs [9][MAXC];
    int expv [9][MAXC];
    string sel_name [9] = '{"edge_cnt", "bit_cnt", "dat_samp_en", "strt_chk_en", "deser_en",
                            "par_chk_en", "stp_chk_en", "data_valid", "frame_err"};

    uart_rx_ctrl dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .prescale(prescale),
        .par_en(par_en),
        .strt_glitch(strt_glitch),
        .par_err(par_err),
        .stp_err(stp_err),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .deser_en(deser_en),
        .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en),
        .data_valid(data_valid)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Checker stages: each answers one cycle after its enable strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            strt_glitch <= strt_chk_en & glitch_cfg;
            par_err     <= par_chk_en & perr_cfg;
            stp_err     <= stp_chk_en & serr_cfg;
        end
    end

    // Output log, one entry per cycle, captured away from the rising edge.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs[0][cyc] <= int'(edge_cnt);
            obs[1][cyc] <= int'(bit_cnt);
            obs[2][cyc] <= int'(dat_samp_en);
            obs[3][cyc] <= int'(strt_chk_en);
            obs[4][cyc] <= int'(deser_en);
            obs[5][cyc] <= int'(par_chk_en);
            obs[6][cyc] <= int'(stp_chk_en);
            obs[7][cyc] <= int'(data_valid);
            obs[8][cyc] <= int'(frame_err);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // Reference timeline for one frame entering START at cycle s; returns the cycle IDLE is back.
    function automatic int plan(input int s, input int p, input bit pe, input bit g,
                                input bit pr, input bit sr);
        int nb;
        int e;
        if (g) nb = 1;
        else if (pe && pr) nb = 10;
        else nb = pe ? 11 : 10;
        e = s + nb * p;
        for (int c = s; c < e; c++) begin
            expv[0][c] = (c - s) % p;
            expv[1][c] = (c - s) / p;
            expv[2][c] = 1;
        end
        expv[3][s + p - 2] = 1;
        if (!g) begin
            for (int k = 1; k <= 8; k++) expv[4][s + k * p + p - 2] = 1;
            if (pe) expv[5][s + 9 * p + p - 2] = 1;
            if (!(pe && pr)) expv[6][s + (nb - 1) * p + p - 2] = 1;
        end
        if (g || (pe && pr) || sr) expv[8][e] = 1;
        else expv[7][e] = 1;
        return e;
    endfunction

    function automatic int diffs(input int sel, input int a, input int b, output int first);
        int n = 0;
        first = -1;
        for (int c = a; c <= b; c++) begin
            if (obs[sel][c] != expv[sel][c]) begin
                if (first < 0) first = c;
                n++;
            end
        end
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    task automatic send(input int p_line, input bit pe, input bit stop_v, output int d);
        logic [10:0] bits;
        logic [7:0]  dat;
        int nb;
        dat = 8'($urandom);
        nb = pe ? 11 : 10;
        bits = 11'h7ff;
        bits[0] = 1'b0;
        bits[8:1] = dat;
        if (pe) bits[9] = ^dat;
        bits[nb - 1] = stop_v;
        d = 0;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < p_line; i++) begin
                @(negedge clk);
                rx_in = bits[b];
                if (b == 0 && i == 0) d = cyc;
            end
        end
    endtask

    task automatic run_frame(input int p_cfg, input bit pe, input bit g, input bit pr,
                             input bit sr, output int s, output int e);
        int d;
        int p_eff;
        prescale = 6'(p_cfg);
        par_en = pe;
        glitch_cfg = g;
        perr_cfg = pr;
        serr_cfg = sr;
        p_eff = (p_cfg < 8 || (p_cfg % 2) != 0) ? 8 : p_cfg;
        if (g) begin
            @(negedge clk);
            rx_in = 1'b0;
            d = cyc;
            @(negedge clk);
            rx_in = 1'b0;
            @(negedge clk);
            rx_in = 1'b1;
        end else begin
            send(p_eff, pe, !sr, d);
        end
        s = (d + 1 > prev_end + 1) ? d + 1 : prev_end + 1;
        e = plan(s, p_eff, pe, g, pr, sr);
        prev_end = e;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (edge_cnt !== 6'd0) $display("FAIL reset_edge: got %0d, required 0", edge_cnt); else passed++;
        checks++; if (bit_cnt !== 4'd0) $display("FAIL reset_bit: got %0d, required 0", bit_cnt); else passed++;
        checks++; if ({dat_samp_en, data_valid, frame_err} !== 3'b000)
            $display("FAIL reset_flags: got %b, required 000", {dat_samp_en, data_valid, frame_err}); else passed++;
        checks++; if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en} !== 4'b0000)
            $display("FAIL reset_strobes: got %b, required 0000", {strt_chk_en, deser_en, par_chk_en, stp_chk_en}); else passed++;
        rst = 1'b1;
        prev_end = cyc;
        idle(6);
        checks++; if ({dat_samp_en, edge_cnt, bit_cnt} !== 11'd0)
            $display("FAIL idle_after_reset: got %0d, required 0", {dat_samp_en, edge_cnt, bit_cnt}); else passed++;
    endtask

    task automatic test_clean_p8;
        int s, e, n, f, cnt;
        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, s, e);
        idle(40);
        for (int sel = 0; sel < NSEL; sel++) begin
            n = diffs(sel, s - 1, e + 2, f);
            checks++;
            if (n !== 0) $display("FAIL clean_p8 %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                  sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
            else passed++;
        end
        cnt = 0;
        for (int c = s; c <= e; c++) cnt += obs[4][c];
        checks++; if (cnt !== 8) $display("FAIL clean_p8_deser_count: got %0d, required 8", cnt); else passed++;
        checks++; if (obs[7][s + 80] !== 1) $display("FAIL clean_p8_valid_at_80: got %0d, required 1", obs[7][s + 80]); else passed++;
    endtask

    task automatic test_error_frames;
        int s, e, n, f;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, s, e);
                1: run_frame(16, 1'b0, 1'b1, 1'b0, 1'b0, s, e);
                default: run_frame(8, 1'b1, 1'b0, 1'b0, 1'b1, s, e);
            endcase
            idle(40);
            for (int sel = 0; sel < NSEL; sel++) begin
                n = diffs(sel, s - 1, e + 2, f);
                checks++;
                if (n !== 0) $display("FAIL error_frame%0d %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                      t, sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int d, s, target, s2, e2, n, f;
        prescale = 6'd8;
        par_en = 1'b0;
        glitch_cfg = 1'b0; perr_cfg = 1'b0; serr_cfg = 1'b0;
        @(negedge clk);
        rx_in = 1'b0;
        d = cyc;
        s = (d + 1 > prev_end + 1) ? d + 1 : prev_end + 1;
        target = s + 4 * 8 + 3;
        while (cyc < target) begin
            @(negedge clk);
            if (cyc >= d + 8) rx_in = 1'b1;
        end
        checks++; if ({bit_cnt, edge_cnt} !== {4'd4, 6'd3})
            $display("FAIL pre_reset_position: got bit %0d edge %0d, required bit 4 edge 3", bit_cnt, edge_cnt); else passed++;
        rst = 1'b0;
        #1;
        checks++; if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err} !== 17'd0)
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err});
        else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        prev_end = cyc;
        idle(3);
        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, s2, e2);
        idle(40);
        for (int sel = 0; sel < NSEL; sel++) begin
            n = diffs(sel, s2 - 1, e2 + 2, f);
            checks++;
            if (n !== 0) $display("FAIL after_reset %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                  sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
            else passed++;
        end
    endtask

    task automatic test_prescale_change;
        int d, s, e, s2, e2, n, f;
        prescale = 6'd16;
        par_en = 1'b0;
        glitch_cfg = 1'b0; perr_cfg = 1'b0; serr_cfg = 1'b0;
        d = 0;
        fork
            send(16, 1'b0, 1'b1, d);
            begin
                repeat (40) @(negedge clk);
                prescale = 6'd8;
            end
        join
        s = (d + 1 > prev_end + 1) ? d + 1 : prev_end + 1;
        e = plan(s, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        prev_end = e;
        idle(10);
        run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, s2, e2);
        idle(40);
        for (int sel = 0; sel < NSEL; sel++) begin
            n = diffs(sel, s - 1, e2 + 2, f);
            checks++;
            if (n !== 0) $display("FAIL prescale_change %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                  sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int s1, e1, s2, e2, n, f, dv;
        run_frame(13, 1'b1, 1'b0, 1'b0, 1'b0, s1, e1);
        run_frame(13, 1'b1, 1'b0, 1'b0, 1'b0, s2, e2);
        idle(40);
        for (int sel = 0; sel < NSEL; sel++) begin
            n = diffs(sel, s1 - 1, e2 + 2, f);
            checks++;
            if (n !== 0) $display("FAIL back_to_back %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                  sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
            else passed++;
        end
        dv = 0;
        for (int c = s1; c <= e2 + 2; c++) dv += obs[7][c];
        checks++; if (dv !== 2) $display("FAIL back_to_back_valid_count: got %0d, required 2", dv); else passed++;
    endtask

    task automatic test_random;
        int opts [5] = '{8, 16, 32, 12, 9};
        int s, e, n, f, kind, p;
        bit pe;
        for (int t = 0; t < 8; t++) begin
            kind = int'($urandom_range(0, 3));
            p = opts[$urandom_range(0, 4)];
            pe = 1'($urandom);
            case (kind)
                0: run_frame(p, pe, 1'b0, 1'b0, 1'b0, s, e);
                1: run_frame(p, pe, 1'b1, 1'b0, 1'b0, s, e);
                2: run_frame(p, 1'b1, 1'b0, 1'b1, 1'b0, s, e);
                default: run_frame(p, pe, 1'b0, 1'b0, 1'b1, s, e);
            endcase
            idle(40 + int'($urandom_range(0, 5)));
            for (int sel = 0; sel < NSEL; sel++) begin
                n = diffs(sel, s - 1, e + 2, f);
                checks++;
                if (n !== 0) $display("FAIL random%0d(kind %0d P %0d) %s: %0d cycle(s) differ, first at %0d: got %0d, required %0d",
                                      t, kind, p, sel_name[sel], n, f, obs[sel][f], expv[sel][f]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_p8();
        test_error_frames();
        test_reset_mid_frame();
        test_prescale_change();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
